// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// The SEQ_TX_PARITY_EN build option is handled in seq_pattern_tx.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    FIN
  } state_e;

  localparam int REPEAT_W = 4;
  localparam int GAP_W    = 8;

  // Wide enough to hold bit indices 0..WIDTH (the parity slot needs index WIDTH).
  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_tx_piso.sv
// Parallel-load, shift-left register; exposes the current MSB.
// Load has priority over shift.
module seq_tx_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb = sh_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched word out MSB-first, REPEAT+1 copies
// separated by GAP_LEN idle cycles. Define SEQ_TX_PARITY_EN to append an even-parity bit.
//
// state | meaning
// IDLE  | waiting for START, outputs at idle level
// SHIFT | a pattern (or parity) bit is on OUT
// GAP   | idle spacing between copies, still busy
// FIN   | one-cycle DONE pulse
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   GAP_LEN    = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [WIDTH-1:0]    PAT,
  input  logic [REPEAT_W-1:0] REPEAT,
  input  logic                ABORT,
  output logic                OUT,
  output logic                OUT_VALID,
  output logic                BUSY,
  output logic                DONE
);

  localparam int BCW = bit_cnt_w(WIDTH);
`ifdef SEQ_TX_PARITY_EN
  localparam int B = WIDTH + 1;
  localparam logic [BCW-1:0] PAR_IDX = BCW'(WIDTH - 1);
`else
  localparam int B = WIDTH;
`endif
  localparam logic [BCW-1:0]   LAST_IDX = BCW'(B - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    pat_q, pat_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [REPEAT_W-1:0] copy_cnt_q, copy_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                out_q, out_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef SEQ_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic             piso_load, piso_shift, piso_msb, reload;
  logic [WIDTH-1:0] piso_din;

  // The first bit goes straight to OUT, so the shifter is loaded one position ahead.
  seq_tx_piso #(.WIDTH(WIDTH)) u_piso (
    .clk   (CLK),
    .rst   (RST),
    .load  (piso_load),
    .shift (piso_shift),
    .din   (piso_din),
    .msb   (piso_msb)
  );

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    bit_cnt_d  = bit_cnt_q;
    copy_cnt_d = copy_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    out_d      = out_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_din   = {pat_q[WIDTH-2:0], 1'b0};
    reload     = 1'b0;

    case (state_q)
      IDLE: begin
        out_d   = IDLE_LEVEL;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (START && !ABORT) begin
          state_d    = SHIFT;
          pat_d      = PAT;
          copy_cnt_d = REPEAT;
          bit_cnt_d  = '0;
          out_d      = PAT[WIDTH-1];
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          piso_load  = 1'b1;
          piso_din   = {PAT[WIDTH-2:0], 1'b0};
`ifdef SEQ_TX_PARITY_EN
          parity_d   = ^PAT;
`endif
        end
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_IDX) begin
          if (copy_cnt_q == '0) begin
            state_d = FIN;
            out_d   = IDLE_LEVEL;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (GAP_LEN > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_INIT;
            out_d     = IDLE_LEVEL;
            valid_d   = 1'b0;
          end else begin
            reload = 1'b1;
          end
        end else begin
          bit_cnt_d  = bit_cnt_q + BCW'(1);
          piso_shift = 1'b1;
          out_d      = piso_msb;
`ifdef SEQ_TX_PARITY_EN
          if (bit_cnt_q == PAR_IDX) begin
            out_d = parity_q;
          end
`endif
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          reload = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        out_d   = IDLE_LEVEL;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      state_d    = SHIFT;
      copy_cnt_d = copy_cnt_q - REPEAT_W'(1);
      bit_cnt_d  = '0;
      out_d      = pat_q[WIDTH-1];
      valid_d    = 1'b1;
      busy_d     = 1'b1;
      piso_load  = 1'b1;
    end

    if (ABORT && state_q != IDLE) begin
      state_d    = IDLE;
      out_d      = IDLE_LEVEL;
      valid_d    = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      bit_cnt_q  <= '0;
      copy_cnt_q <= '0;
      gap_cnt_q  <= '0;
      out_q      <= IDLE_LEVEL;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      bit_cnt_q  <= bit_cnt_d;
      copy_cnt_q <= copy_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SEQ_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: expected per-cycle output streams are built from the
// transfer rules (bits, gaps, DONE) and compared every cycle. Honours SEQ_TX_PARITY_EN.
module tb_seq_pattern_tx;

  localparam int   W        = 8;
  localparam int   GAP      = 2;
  localparam logic IDLE_LVL = 1'b0;

  typedef struct packed {
    logic o;
    logic v;
    logic b;
    logic d;
  } cyc_t;

  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] PAT = '0;
  logic [3:0]   REPEAT = '0;
  logic         ABORT = 1'b0;
  logic         OUT, OUT_VALID, BUSY, DONE;

  int   vectors = 0;
  int   errors  = 0;
  cyc_t exp_q[$];

  seq_pattern_tx #(.WIDTH(W), .GAP_LEN(GAP), .IDLE_LEVEL(IDLE_LVL)) dut (
    .CLK       (clk),
    .RST       (RST),
    .START     (START),
    .PAT       (PAT),
    .REPEAT    (REPEAT),
    .ABORT     (ABORT),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check_cycle(input string tag, input cyc_t e, input int idx);
    chk($sformatf("%s[%0d].out", tag, idx),   OUT,       e.o);
    chk($sformatf("%s[%0d].valid", tag, idx), OUT_VALID, e.v);
    chk($sformatf("%s[%0d].busy", tag, idx),  BUSY,      e.b);
    chk($sformatf("%s[%0d].done", tag, idx),  DONE,      e.d);
  endtask

  // One transfer, cycle by cycle from the cycle after the START edge, plus one trailing idle cycle.
  function automatic void push_xfer(input logic [W-1:0] p, input int rep);
    for (int c = 0; c <= rep; c++) begin
      for (int b = W - 1; b >= 0; b--) exp_q.push_back(cyc_t'{p[b], 1'b1, 1'b1, 1'b0});
`ifdef SEQ_TX_PARITY_EN
      exp_q.push_back(cyc_t'{^p, 1'b1, 1'b1, 1'b0});
`endif
      if (c < rep) begin
        for (int g = 0; g < GAP; g++) exp_q.push_back(cyc_t'{IDLE_LVL, 1'b0, 1'b1, 1'b0});
      end
    end
    exp_q.push_back(cyc_t'{IDLE_LVL, 1'b0, 1'b0, 1'b1});
    exp_q.push_back(cyc_t'{IDLE_LVL, 1'b0, 1'b0, 1'b0});
  endfunction

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle(tag, cyc_t'{IDLE_LVL, 1'b0, 1'b0, 1'b0}, i);
    end
  endtask

  // mode 0: plain, 1: START/PAT/REPEAT disturbed mid-word, 2: START held for two transfers
  task automatic xfer(input string tag, input logic [W-1:0] p, input int rep, input int mode);
    int len1;
    exp_q.delete();
    push_xfer(p, rep);
    len1 = exp_q.size();
    if (mode == 2) push_xfer(p, rep);
    @(negedge clk);
    START = 1'b1; PAT = p; REPEAT = rep[3:0];
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_cycle(tag, exp_q[i], i);
      if ((mode != 2 && i == 0) || (mode == 2 && i == len1)) begin
        START = 1'b0; PAT = W'($urandom); REPEAT = 4'($urandom);
      end
      if (mode == 1 && i == 2) begin
        START = 1'b1; PAT = ~p; REPEAT = 4'hF;
      end
      if (mode == 1 && i == 3) START = 1'b0;
    end
  endtask

  task automatic abort_at(input string tag, input logic [W-1:0] p, input int rep, input int at);
    exp_q.delete();
    push_xfer(p, rep);
    @(negedge clk);
    START = 1'b1; PAT = p; REPEAT = rep[3:0];
    for (int i = 0; i < at; i++) begin
      @(negedge clk);
      if (i == 0) START = 1'b0;
      check_cycle(tag, exp_q[i], i);
    end
    ABORT = 1'b1;
    @(negedge clk);
    ABORT = 1'b0;
    check_cycle({tag, "_aborted"}, cyc_t'{IDLE_LVL, 1'b0, 1'b0, 1'b0}, at);
    check_idle({tag, "_after"}, 3 * W);
  endtask

  initial begin
    // reset then idle
    #30 RST = 1'b0;
    check_cycle("reset", cyc_t'{IDLE_LVL, 1'b0, 1'b0, 1'b0}, 0);
    check_idle("idle", 20);

    // directed transfers
    xfer("single_e3", 8'hE3, 0, 0);
    xfer("rep_a5", 8'hA5, 2, 0);
    xfer("parity0_03", 8'h03, 0, 0);
    xfer("busy_prot", 8'h96, 1, 1);
    xfer("back2back", 8'h5C, 1, 2);

    // aborts in SHIFT and in GAP
    abort_at("abort_shift", 8'hE3, 0, 4);
    abort_at("abort_gap", 8'h3C, 2, W + 1);

    // reset mid-transfer, checked before any clock edge
    exp_q.delete();
    push_xfer(8'hC9, 1);
    @(negedge clk);
    START = 1'b1; PAT = 8'hC9; REPEAT = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) START = 1'b0;
      check_cycle("pre_rst", exp_q[i], i);
    end
    #2 RST = 1'b1;
    #1 check_cycle("async_rst", cyc_t'{IDLE_LVL, 1'b0, 1'b0, 1'b0}, 0);
    @(negedge clk);
    RST = 1'b0;
    check_idle("post_rst", 2 * W);

    // START and ABORT together in IDLE
    @(negedge clk);
    START = 1'b1; ABORT = 1'b1; PAT = 8'hFF;
    check_idle("collide", 4);
    START = 1'b0; ABORT = 1'b0;
    check_idle("collide_after", 2);

    // randomized transfers
    for (int n = 0; n < 8; n++) begin
      xfer($sformatf("rand%0d", n), W'($urandom), int'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
